controle_preparo: RTL and testbench

Brew sequencer sitting directly downstream of the sensor-check machine: consumes its 2-bit status (00 analysing, 01 error, 10 no errors, 11 sensor fault) and, on a user start request, runs the timed heat → pump → drip sequence. It drives the heater, pump and dispense valve, reports completion, and produces a 4-bit display code. Any sensor fault locks the machine until reset.

---
 rtl/preparo_pkg.sv | 37 +++
 rtl/controle_preparo_if.sv | 25 ++
 rtl/contador_fase.sv | 29 ++
 rtl/controle_preparo.sv | 118 +++++++++++
 tb/tb_controle_preparo.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/preparo_pkg.sv
// Shared definitions for the brew sequencer.
// - Display codes, which double as the FSM state encoding.
// - Sensor-check status codes.
// - Display helper function.
package preparo_pkg;

  localparam logic [3:0] COD_OCIOSO     = 4'b0000;
  localparam logic [3:0] COD_AGUARDA    = 4'b0001;
  localparam logic [3:0] COD_AQUECENDO  = 4'b0010;
  localparam logic [3:0] COD_BOMBEANDO  = 4'b0011;
  localparam logic [3:0] COD_GOTEJANDO  = 4'b0100;
  localparam logic [3:0] COD_CONCLUIDO  = 4'b1000;
  localparam logic [3:0] COD_ABORTADO   = 4'b1001;
  localparam logic [3:0] COD_BLOQUEADO  = 4'b1111;

  // The state encoding is the display code, so the display is a plain copy.
  typedef enum logic [3:0] {
    OCIOSO           = COD_OCIOSO,
    AGUARDA_SENSORES = COD_AGUARDA,
    AQUECENDO        = COD_AQUECENDO,
    BOMBEANDO        = COD_BOMBEANDO,
    GOTEJANDO        = COD_GOTEJANDO,
    CONCLUIDO        = COD_CONCLUIDO,
    ABORTADO         = COD_ABORTADO,
    BLOQUEADO        = COD_BLOQUEADO
  } estado_t;

  localparam logic [1:0] ST_ANALISE      = 2'b00;
  localparam logic [1:0] ST_ERRO         = 2'b01;
  localparam logic [1:0] ST_OK           = 2'b10;
  localparam logic [1:0] ST_FALHA_SENSOR = 2'b11;

  function automatic logic [3:0] codigo_display(estado_t e);
    return 4'(e);
  endfunction

endpackage

// File: rtl/controle_preparo_if.sv
// Handshake/bus bundle between the brew sequencer and its user/sensor side.
// - master: drives the start button, drink type and sensor status; observes outputs.
// - slave:  the sequencer itself.
interface controle_preparo_if;
  logic       INICIAR;
  logic       TIPO;
  logic [1:0] STATUS_SENSORES;
  logic       AQUECEDOR;
  logic       BOMBA;
  logic       VALVULA;
  logic       OCUPADO;
  logic       PRONTO;
  logic       FALHA;
  logic [3:0] CODIGO_DISPLAY;

  modport master (
    output INICIAR, TIPO, STATUS_SENSORES,
    input  AQUECEDOR, BOMBA, VALVULA, OCUPADO, PRONTO, FALHA, CODIGO_DISPLAY
  );

  modport slave (
    input  INICIAR, TIPO, STATUS_SENSORES,
    output AQUECEDOR, BOMBA, VALVULA, OCUPADO, PRONTO, FALHA, CODIGO_DISPLAY
  );
endinterface

// File: rtl/contador_fase.sv
// Phase counter: CW-bit up-counter with synchronous clear and a terminal-count
// flag against a runtime limit (limit = phase length - 1).
// Ports:
// - clk_i, rst_ni : clock, async active-low reset
// - clr_i         : synchronous clear (counter loads 0 on the next edge)
// - lim_i         : terminal value
// - fim_o         : high while the counter equals lim_i
module contador_fase #(
  parameter int unsigned CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic [CW-1:0] lim_i,
  output logic          fim_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb cnt_d = clr_i ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign fim_o = (cnt_q == lim_i);

endmodule

// File: rtl/controle_preparo.sv
// Brew sequencer: on a start edge waits for the sensor machine to report OK,
// then runs heat -> pump -> drip, pulses PRONTO and returns to idle. A sensor
// fault while busy locks the machine until reset.
// Ports:
// - CLK, RST_N : clock, async active-low reset
// - bus        : controle_preparo_if.slave (start, type, status in; actuators,
//                busy, done, fault, display out)
module controle_preparo
  import preparo_pkg::*;
#(
  parameter int unsigned CW            = 8,
  parameter int unsigned T_ESPERA      = 32,
  parameter int unsigned T_AQUECE      = 8,
  parameter int unsigned T_BOMBA_CURTO = 6,
  parameter int unsigned T_BOMBA_LONGO = 12,
  parameter int unsigned T_GOTEJO      = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  controle_preparo_if.slave   bus
);

  localparam logic [CW-1:0] LIM_ESPERA = CW'(T_ESPERA - 1);
  localparam logic [CW-1:0] LIM_AQUECE = CW'(T_AQUECE - 1);
  localparam logic [CW-1:0] LIM_CURTO  = CW'(T_BOMBA_CURTO - 1);
  localparam logic [CW-1:0] LIM_LONGO  = CW'(T_BOMBA_LONGO - 1);
  localparam logic [CW-1:0] LIM_GOTEJO = CW'(T_GOTEJO - 1);

  estado_t       estado_q, estado_d;
  logic          ini_prev_q;
  logic          tipo_q, tipo_d;
  logic          partida, ativo, fim, clr;
  logic [CW-1:0] lim;

  // Previous button level resets to 1 so a button held through reset never starts.
  assign partida = bus.INICIAR & ~ini_prev_q;
  assign ativo   = (estado_q == AGUARDA_SENSORES) || (estado_q == AQUECENDO) ||
                   (estado_q == BOMBEANDO) || (estado_q == GOTEJANDO);

  // Counter restarts on every state change and is held at 0 in untimed states.
  assign clr = (estado_d != estado_q) || !ativo;

  always_comb begin
    lim = '0;
    case (estado_q)
      AGUARDA_SENSORES: lim = LIM_ESPERA;
      AQUECENDO:        lim = LIM_AQUECE;
      BOMBEANDO:        lim = tipo_q ? LIM_LONGO : LIM_CURTO;
      GOTEJANDO:        lim = LIM_GOTEJO;
      default:          lim = '0;
    endcase
  end

  contador_fase #(.CW(CW)) u_contador (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .clr_i  (clr),
    .lim_i  (lim),
    .fim_o  (fim)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      estado_q   <= OCIOSO;
      ini_prev_q <= 1'b1;
      tipo_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      ini_prev_q <= bus.INICIAR;
      tipo_q     <= tipo_d;
    end
  end

  // Sensor fault is tested first in every busy state so it wins over phase end.
  always_comb begin
    estado_d = estado_q;
    tipo_d   = tipo_q;
    case (estado_q)
      OCIOSO: if (partida) begin
        estado_d = AGUARDA_SENSORES;
        tipo_d   = bus.TIPO;
      end
      AGUARDA_SENSORES: begin
        if      (bus.STATUS_SENSORES == ST_FALHA_SENSOR) estado_d = BLOQUEADO;
        else if (bus.STATUS_SENSORES == ST_OK)           estado_d = AQUECENDO;
        else if (fim)                                    estado_d = ABORTADO;
      end
      AQUECENDO: begin
        if      (bus.STATUS_SENSORES == ST_FALHA_SENSOR) estado_d = BLOQUEADO;
        else if (fim)                                    estado_d = BOMBEANDO;
      end
      BOMBEANDO: begin
        if      (bus.STATUS_SENSORES == ST_FALHA_SENSOR) estado_d = BLOQUEADO;
        else if (fim)                                    estado_d = GOTEJANDO;
      end
      GOTEJANDO: begin
        if      (bus.STATUS_SENSORES == ST_FALHA_SENSOR) estado_d = BLOQUEADO;
        else if (fim)                                    estado_d = CONCLUIDO;
      end
      CONCLUIDO: estado_d = OCIOSO;
      ABORTADO:  estado_d = OCIOSO;
      BLOQUEADO: estado_d = BLOQUEADO;
      default:   estado_d = OCIOSO;
    endcase
  end

  // Moore outputs, decoded from the registered state only.
  always_comb begin
    bus.AQUECEDOR      = (estado_q == AQUECENDO) || (estado_q == BOMBEANDO);
    bus.BOMBA          = (estado_q == BOMBEANDO);
    bus.VALVULA        = (estado_q == BOMBEANDO) || (estado_q == GOTEJANDO);
    bus.OCUPADO        = ativo;
    bus.PRONTO         = (estado_q == CONCLUIDO);
    bus.FALHA          = (estado_q == BLOQUEADO);
    bus.CODIGO_DISPLAY = codigo_display(estado_q);
  end

endmodule

// File: tb/tb_controle_preparo.sv
// Bench for controle_preparo: builds the expected per-cycle display timeline of
// each brew from the phase durations, derives the actuator levels from the
// display code, and compares every cycle. Directed scenarios first, then
// randomized ones (drink type, wait length, fault or reset injection).
module tb_controle_preparo;

  localparam int TE = 32, TA = 8, TBC = 6, TBL = 12, TG = 4;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   checks = 0;
  int   failures = 0;

  controle_preparo_if bus();

  controle_preparo #(
    .CW(8), .T_ESPERA(TE), .T_AQUECE(TA),
    .T_BOMBA_CURTO(TBC), .T_BOMBA_LONGO(TBL), .T_GOTEJO(TG)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // {display, heater, pump, valve, busy, done, fault} expected for a display code
  function automatic logic [9:0] esperado(logic [3:0] c);
    logic aq, bo, va, oc, pr, fa;
    aq = (c == 4'h2) || (c == 4'h3);
    bo = (c == 4'h3);
    va = (c == 4'h3) || (c == 4'h4);
    oc = (c >= 4'h1) && (c <= 4'h4);
    pr = (c == 4'h8);
    fa = (c == 4'hF);
    return {c, aq, bo, va, oc, pr, fa};
  endfunction

  function automatic logic [9:0] observado();
    return {bus.CODIGO_DISPLAY, bus.AQUECEDOR, bus.BOMBA, bus.VALVULA,
            bus.OCUPADO, bus.PRONTO, bus.FALHA};
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reset pulled between clock edges: outputs must drop without any edge.
  task automatic reset_meio();
    #2 RST_N = 1'b0;
    #1 chk("reset_async", observado(), esperado(4'h0));
    @(negedge CLK);
    chk("reset_held", observado(), esperado(4'h0));
    RST_N = 1'b1;
  endtask

  // ff/rf: -1 none, -2 random busy cycle, >=0 explicit timeline index.
  task automatic brew(input bit tipo, input int w, input int ff_in, input int rf_in,
                      input bit only01);
    logic [3:0] exp_q[$];
    logic [1:0] st_q[$];
    int tb, nact, ff, rf;
    tb = tipo ? TBL : TBC;
    ff = ff_in;
    rf = rf_in;
    if (w >= TE) begin
      repeat (TE) begin
        exp_q.push_back(4'h1);
        st_q.push_back(only01 ? 2'b01 : 2'($urandom_range(0, 1)));
      end
      exp_q.push_back(4'h9); st_q.push_back(2'($urandom_range(0, 2)));
    end else begin
      repeat (w) begin
        exp_q.push_back(4'h1);
        st_q.push_back(only01 ? 2'b01 : 2'($urandom_range(0, 1)));
      end
      exp_q.push_back(4'h1); st_q.push_back(2'b10);
      repeat (TA) begin exp_q.push_back(4'h2); st_q.push_back(2'($urandom_range(0, 2))); end
      repeat (tb) begin exp_q.push_back(4'h3); st_q.push_back(2'($urandom_range(0, 2))); end
      repeat (TG) begin exp_q.push_back(4'h4); st_q.push_back(2'($urandom_range(0, 2))); end
      exp_q.push_back(4'h8); st_q.push_back(2'($urandom_range(0, 2)));
    end
    repeat (3) begin exp_q.push_back(4'h0); st_q.push_back(2'($urandom_range(0, 3))); end

    nact = 0;
    foreach (exp_q[i]) if (exp_q[i] >= 4'h1 && exp_q[i] <= 4'h4) nact++;
    if (ff == -2) ff = int'($urandom_range(0, nact - 1));
    if (rf == -2) rf = int'($urandom_range(0, nact - 1));
    if (ff >= 0) begin
      st_q[ff] = 2'b11;
      while (exp_q.size() > ff + 1) begin void'(exp_q.pop_back()); void'(st_q.pop_back()); end
      repeat (4) begin exp_q.push_back(4'hF); st_q.push_back(2'($urandom_range(0, 3))); end
    end

    @(negedge CLK);
    chk("idle_pre", observado(), esperado(4'h0));
    bus.INICIAR = 1'b0;
    @(negedge CLK);
    chk("idle_arm", observado(), esperado(4'h0));
    bus.INICIAR = 1'b1;
    bus.TIPO = tipo;
    bus.STATUS_SENSORES = 2'b00;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge CLK);
      chk($sformatf("cyc%0d", k), observado(), esperado(exp_q[k]));
      bus.STATUS_SENSORES = st_q[k];
      bus.TIPO = 1'($urandom_range(0, 1));
      // Extra presses while not idle must be ignored; idle keeps the level.
      if (exp_q[k] != 4'h0) bus.INICIAR = 1'($urandom_range(0, 1));
      if (k == rf) begin
        reset_meio();
        break;
      end
    end
    if (ff >= 0) reset_meio();
  endtask

  initial begin
    bus.INICIAR = 1'b1;
    bus.TIPO = 1'b0;
    bus.STATUS_SENSORES = 2'b00;
    #3 chk("reset_state", observado(), esperado(4'h0));
    @(negedge CLK);
    RST_N = 1'b1;
    // Button held through reset release never starts.
    repeat (5) begin
      @(negedge CLK);
      chk("held_button", observado(), esperado(4'h0));
    end

    brew(1'b0, 0, -1, -1, 1'b0);              // short drink, immediate OK
    brew(1'b1, 3, -1, -1, 1'b0);              // long drink, type toggled while running
    brew(1'b0, 40, -1, -1, 1'b1);             // status held 01 -> abort
    brew(1'b0, 0, 1 + TA + TBC - 1, -1, 1'b0); // fault on last pump cycle
    brew(1'b1, 0, -1, 1 + TA + 2, 1'b0);       // reset mid-pump
    brew(1'b1, 0, -1, -1, 1'b0);              // full run after reset
    brew(1'b0, TE - 1, -1, -1, 1'b0);         // OK on last wait cycle

    for (int r = 0; r < 24; r++) begin
      int modo;
      modo = int'($urandom_range(0, 3));
      brew(1'($urandom_range(0, 1)), int'($urandom_range(0, 40)),
           (modo == 2) ? -2 : -1, (modo == 3) ? -2 : -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
